// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   Receive side of the board RS-232 port. UART_RXD is oversampled at 16x the
//   baud rate and decoded as 8N1, LSB first. Good bytes go into a small FIFO
//   that is offered to the host on a valid/ready interface. UART_CTS throttles
//   the far end when the FIFO is nearly full.
//
// Handshake: a byte transfers on every rising edge of CLOCK_50 where
//   rx_valid=1 and rx_ready=1. While rx_valid=1 and rx_ready=0, rx_data holds
//   steady. rx_valid does not depend on rx_ready. rx_data reads 0 when
//   rx_valid=0.
//
// Ports:
//   CLOCK_50     in   single clock, rising edge
//   reset        in   synchronous, active-high
//   UART_RXD     in   asynchronous serial input, idles high
//   UART_CTS     out  active-low clear-to-send (1 = stop sending)
//   rx_data      out  byte at the FIFO head
//   rx_valid     out  FIFO non-empty
//   rx_ready     in   consumer accepts the head byte
//   framing_err  out  one-cycle pulse: stop bit sampled as 0
//   overrun      out  one-cycle pulse: good byte dropped, FIFO full
//   fsm_state_o  out  debug view of the receive FSM
//                     (0 IDLE, 1 START, 2 DATA, 3 STOP)
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV        = (CLK_HZ + 8 * BAUD) / (16 * BAUD)
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       UART_RXD,
    output logic       UART_CTS,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_err,
    output logic       overrun,
    output logic [1:0] fsm_state_o
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer and tick generator
    // ------------------------------------------------------------------
    logic          sync1_q, rxs_q, rxs_prev_q;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tick;

    assign tick   = (tcnt_q == TW'(DIV - 1));
    assign tcnt_d = tick ? '0 : tcnt_q + 1'b1;

    // rxs_prev_q follows rxs_q only on ticks, so a fall is seen as a
    // tick-to-tick change and cannot be missed between ticks. It also keeps
    // tracking during a frame, which means a line stuck low after a bad stop
    // bit produces no new start until it has gone high again.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            tcnt_q     <= '0;
        end else begin
            sync1_q <= UART_RXD;
            rxs_q   <= sync1_q;
            tcnt_q  <= tcnt_d;
            if (tick) begin
                rxs_prev_q <= rxs_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [3:0] os_q, os_d;
    logic [2:0] bi_q, bi_d;
    logic [7:0] shreg_q, shreg_d;
    logic       push;
    logic       ferr_d;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            os_q    <= '0;
            bi_q    <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            os_q    <= os_d;
            bi_q    <= bi_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        os_d    = os_q;
        bi_d    = bi_q;
        shreg_d = shreg_q;
        push    = 1'b0;
        ferr_d  = 1'b0;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (rxs_prev_q && !rxs_q) begin
                        os_d    = '0;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    // Mid start bit: a high line means the fall was a glitch.
                    if (os_q == 4'd7) begin
                        if (rxs_q) begin
                            state_d = S_IDLE;
                        end else begin
                            os_d    = '0;
                            bi_d    = '0;
                            state_d = S_DATA;
                        end
                    end else begin
                        os_d = os_q + 4'd1;
                    end
                end
                S_DATA: begin
                    // os wraps 15 -> 0, giving one sample per 16 ticks.
                    os_d = os_q + 4'd1;
                    if (os_q == 4'd15) begin
                        shreg_d[bi_q] = rxs_q;
                        bi_d          = bi_q + 3'd1;
                        if (bi_q == 3'd7) begin
                            state_d = S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    os_d = os_q + 4'd1;
                    if (os_q == 4'd15) begin
                        state_d = S_IDLE;
                        if (rxs_q) begin
                            push = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign fsm_state_o = state_q;

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW-1:0] count;
    logic          empty, full, pop, wr_en;
    logic          ovr_d, cts_d;
    logic          cts_q, ferr_q, ovr_q;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = rx_valid && rx_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO still
    // accepts the byte.
    assign wr_en = push && (!full || pop);
    assign ovr_d = push && full && !pop;
    assign count = wr_ptr_q - rd_ptr_q;
    assign cts_d = (count >= PW'(FIFO_DEPTH - 1));

    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cts_q    <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cts_q  <= cts_d;
            ferr_q <= ferr_d;
            ovr_q  <= ovr_d;
        end
    end

    assign rx_valid    = !empty;
    assign rx_data     = rx_valid ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
    assign UART_CTS    = cts_q;
    assign framing_err = ferr_q;
    assign overrun     = ovr_q;

endmodule
